// File: rtl/i2c_regbridge_if.sv
// Signal bundle between i2c_regbridge, its i2cslv instance and the local register client.
// The master modport is the bridge's view; the slave modport is the surrounding logic's view.
interface i2c_regbridge_if;
   logic       s_ack;
   logic       s_dir;
   logic [6:0] s_dev;
   logic [7:0] s_in;
   logic       s_start;
   logic       s_stop;
   logic       s_ok;
   logic [7:0] s_out;
   logic       reg_req;
   logic       reg_we;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       reg_ack;
   logic       err;

   modport master (
      input  s_ack, s_dir, s_dev, s_in, s_start, s_stop, reg_rdata, reg_ack,
      output s_ok, s_out, reg_req, reg_we, reg_addr, reg_wdata, err
   );

   modport slave (
      output s_ack, s_dir, s_dev, s_in, s_start, s_stop, reg_rdata, reg_ack,
      input  s_ok, s_out, reg_req, reg_we, reg_addr, reg_wdata, err
   );
endinterface

// File: rtl/i2c_regbridge.sv
// EEPROM-style I2C register target: turns i2cslv ack/start/stop strobes into pointer updates
// and single-beat register bus requests, and supplies the next byte to transmit.
module i2c_regbridge #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   i2c_regbridge_if.master bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_ADDR,
      PH_PTR,
      PH_WDATA,
      PH_RDATA
   } phase_e;

   phase_e          phase_q, phase_d;
   logic [7:0]      ptr_q, ptr_d;
   logic            ack_q;
   logic [TW-1:0]   timer_q, timer_d;
   logic [7:0]      s_out_q, s_out_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            err_q, err_d;

   logic            ackr;
   logic            issue;
   logic            issue_we;
   logic [7:0]      issue_addr;

   assign ackr = bus.s_ack & ~ack_q;

   assign bus.s_ok      = en & (bus.s_dev == DEV_ADDR);
   assign bus.s_out     = s_out_q;
   assign bus.reg_req   = req_q;
   assign bus.reg_we    = we_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.err       = err_q;

   // Phase sequencing; every byte boundary is marked by the rising edge of s_ack.
   always_comb begin
      phase_d    = phase_q;
      ptr_d      = ptr_q;
      issue      = 1'b0;
      issue_we   = 1'b0;
      issue_addr = ptr_q;
      if (bus.s_start) begin
         phase_d = PH_ADDR;
      end else if (bus.s_stop) begin
         phase_d = PH_IDLE;
      end else if (ackr) begin
         case (phase_q)
            PH_ADDR: begin
               // A mismatched address is NACKed by i2cslv; nothing here may change.
               if (!bus.s_ok) begin
                  phase_d = PH_IDLE;
               end else if (bus.s_dir) begin
                  phase_d = PH_RDATA;
                  issue   = 1'b1;
               end else begin
                  phase_d = PH_PTR;
               end
            end
            PH_PTR: begin
               ptr_d   = bus.s_in;
               phase_d = PH_WDATA;
            end
            PH_WDATA: begin
               issue    = 1'b1;
               issue_we = 1'b1;
               ptr_d    = ptr_q + 8'd1;
            end
            PH_RDATA: begin
               issue      = 1'b1;
               issue_addr = ptr_q + 8'd1;
               ptr_d      = ptr_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Register bus: one outstanding request; reads are bounded by the timer, writes are not.
   always_comb begin
      s_out_d = s_out_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      timer_d = timer_q;
      err_d   = 1'b0;
      if (req_q) begin
         if (bus.reg_ack) begin
            req_d = 1'b0;
            if (!we_q) s_out_d = bus.reg_rdata;
         end else if (!we_q) begin
            if (timer_q == TLAST) begin
               req_d   = 1'b0;
               s_out_d = 8'hFF;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         if (issue) err_d = 1'b1;
      end else if (issue) begin
         req_d   = 1'b1;
         we_d    = issue_we;
         addr_d  = issue_addr;
         timer_d = '0;
         if (issue_we) wdata_d = bus.s_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= PH_IDLE;
         ptr_q   <= 8'h00;
         ack_q   <= 1'b0;
         timer_q <= '0;
         s_out_q <= 8'hFF;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         ptr_q   <= ptr_d;
         ack_q   <= bus.s_ack;
         timer_q <= timer_d;
         s_out_q <= s_out_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_i2c_regbridge.sv
// Directed bench for i2c_regbridge: register-bus transactions are queued as stimulus is issued
// and checked by an independent monitor together with the returned read byte.
module tb_i2c_regbridge;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b1;

   i2c_regbridge_if bus();

   i2c_regbridge #(.DEV_ADDR(7'h50), .TIMEOUT(255)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   err_seen = 0;
   int   err_exp = 0;
   logic [7:0] mem [256];
   logic resp_on = 1'b1;
   int   resp_dly = 2;
   int   dly_cnt = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.data = d;
      exp_q.push_back(t);
   endtask

   task automatic do_start();
      bus.s_start = 1'b1; tick(1); bus.s_start = 1'b0; tick(1);
   endtask

   task automatic do_stop();
      bus.s_stop = 1'b1; tick(1); bus.s_stop = 1'b0; tick(1);
   endtask

   task automatic slot(input logic dir, input logic [7:0] b, input int gap);
      bus.s_dir = dir; bus.s_in = b; bus.s_ack = 1'b1;
      tick(3);
      bus.s_ack = 1'b0;
      tick(gap);
   endtask

   // Register client: acknowledges after resp_dly cycles, backed by mem.
   initial begin
      bus.reg_ack = 1'b0;
      bus.reg_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (bus.reg_ack) begin
            bus.reg_ack = 1'b0;
         end else if (bus.reg_req && resp_on && !reset) begin
            if (dly_cnt >= resp_dly) begin
               bus.reg_ack = 1'b1;
               bus.reg_rdata = bus.reg_we ? 8'h00 : mem[bus.reg_addr];
               if (bus.reg_we) mem[bus.reg_addr] = bus.reg_wdata;
               dly_cnt = 0;
            end else begin
               dly_cnt++;
            end
         end else begin
            dly_cnt = 0;
         end
      end
   end

   // Monitor: pops the expected transaction on each completed request.
   initial begin
      txn_t t;
      logic rd_chk;
      logic [7:0] rd_exp;
      rd_chk = 1'b0;
      rd_exp = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.err) err_seen++;
         if (rd_chk) begin
            chk("rd_byte", 16'(bus.s_out), 16'(rd_exp));
            rd_chk = 1'b0;
         end
         if (bus.reg_req && bus.reg_ack) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_req we=%0b addr=%0h required none", bus.reg_we, bus.reg_addr);
            end else begin
               t = exp_q.pop_front();
               chk("req_we", 16'(bus.reg_we), 16'(t.we));
               chk("req_addr", 16'(bus.reg_addr), 16'(t.addr));
               if (t.we) chk("req_wdata", 16'(bus.reg_wdata), 16'(t.data));
               else begin rd_chk = 1'b1; rd_exp = t.data; end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'hE1; mem[8'h12] = 8'h3C; mem[8'h13] = 8'h4D;
      mem[8'h20] = 8'h5A; mem[8'h21] = 8'hC3; mem[8'h22] = 8'h77;
      bus.s_ack = 1'b0; bus.s_dir = 1'b0; bus.s_dev = 7'h00; bus.s_in = 8'h00;
      bus.s_start = 1'b0; bus.s_stop = 1'b0;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_s_out", 16'(bus.s_out), 16'h00FF);
      chk("rst_req", 16'(bus.reg_req), 16'h0);
      chk("rst_we", 16'(bus.reg_we), 16'h0);
      chk("rst_addr", 16'(bus.reg_addr), 16'h0);
      chk("rst_wdata", 16'(bus.reg_wdata), 16'h0);
      chk("rst_err", 16'(bus.err), 16'h0);
      tick(1);

      // Write pointer 0x10 then two data bytes.
      do_start();
      bus.s_dev = 7'h50; #1;
      chk("s_ok_match", 16'(bus.s_ok), 16'h1);
      slot(1'b0, 8'h00, 6);
      slot(1'b0, 8'h10, 6);
      push(1'b1, 8'h10, 8'hAA); slot(1'b0, 8'hAA, 10);
      push(1'b1, 8'h11, 8'hBB); slot(1'b0, 8'hBB, 10);
      do_stop();
      chk("mem_10", 16'(mem[8'h10]), 16'h00AA);
      chk("mem_11", 16'(mem[8'h11]), 16'h00BB);

      // Current-address read proves ptr landed on 0x12.
      do_start();
      push(1'b0, 8'h12, 8'h3C); slot(1'b1, 8'h00, 10);
      push(1'b0, 8'h13, 8'h4D); slot(1'b1, 8'h00, 10);
      do_stop();

      // Random read: pointer 0x20, repeated start, two bytes.
      do_start();
      slot(1'b0, 8'h00, 6);
      slot(1'b0, 8'h20, 6);
      do_start();
      push(1'b0, 8'h20, 8'h5A); slot(1'b1, 8'h00, 10);
      push(1'b0, 8'h21, 8'hC3); slot(1'b1, 8'h00, 10);
      push(1'b0, 8'h22, 8'h77); slot(1'b1, 8'h00, 10);
      do_stop();

      // Foreign address 0x51 and disabled bridge.
      do_start();
      bus.s_dev = 7'h51; #1;
      chk("s_ok_0x51", 16'(bus.s_ok), 16'h0);
      slot(1'b1, 8'h00, 10);
      slot(1'b1, 8'h00, 10);
      do_stop();
      bus.s_dev = 7'h50; en = 1'b0; #1;
      chk("s_ok_dis", 16'(bus.s_ok), 16'h0);
      en = 1'b1;
      do_start();
      push(1'b0, 8'h22, 8'h77); slot(1'b1, 8'h00, 10);
      do_stop();

      // Asynchronous reset with a read pending.
      resp_on = 1'b0;
      do_start();
      slot(1'b1, 8'h00, 2);
      chk("pend_req", 16'(bus.reg_req), 16'h1);
      @(negedge clk); #2;
      reset = 1'b1; #1;
      chk("arst_req", 16'(bus.reg_req), 16'h0);
      chk("arst_s_out", 16'(bus.s_out), 16'h00FF);
      tick(2);
      reset = 1'b0;
      resp_on = 1'b1;
      tick(1);
      slot(1'b0, 8'h99, 10);
      do_start();
      push(1'b0, 8'h00, 8'hE1); slot(1'b1, 8'h00, 10);
      do_stop();

      // Read timeout: client never answers.
      resp_on = 1'b0;
      do_start();
      bus.s_dir = 1'b1; bus.s_ack = 1'b1;
      for (int i = 0; i < 10 && !bus.reg_req; i++) @(negedge clk);
      chk("to_req_up", 16'(bus.reg_req), 16'h1);
      bus.s_ack = 1'b0;
      n = 0;
      while (!bus.err && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", 16'(n), 16'd255);
      chk("to_s_out", 16'(bus.s_out), 16'h00FF);
      chk("to_req", 16'(bus.reg_req), 16'h0);
      err_exp++;
      tick(2);
      do_stop();
      resp_on = 1'b1;

      // Pointer wrap 0xFF -> 0x00.
      do_start();
      slot(1'b0, 8'h00, 6);
      slot(1'b0, 8'hFF, 6);
      push(1'b1, 8'hFF, 8'h11); slot(1'b0, 8'h11, 10);
      push(1'b1, 8'h00, 8'h22); slot(1'b0, 8'h22, 10);
      do_stop();

      // Overrun: second write arrives while the first is still pending.
      resp_dly = 30;
      do_start();
      slot(1'b0, 8'h00, 6);
      slot(1'b0, 8'h40, 6);
      push(1'b1, 8'h40, 8'h01); slot(1'b0, 8'h01, 2);
      slot(1'b0, 8'h02, 45);
      err_exp++;
      do_stop();
      resp_dly = 2;
      chk("ovr_mem40", 16'(mem[8'h40]), 16'h0001);
      chk("ovr_mem41", 16'(mem[8'h41]), 16'h0000);

      tick(5);
      chk("err_pulses", 16'(err_seen), 16'(err_exp));
      chk("queue_empty", 16'(exp_q.size()), 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
